audio_pingpong_frame_ctrl: RTL and testbench

//  Single-clock ping-pong frame sequencer for one 1024x32 distributed simple-dual-port RAM.
//  The RAM is split into two banks by the address MSB; each bank holds one frame.
//  An input audio sample stream fills one bank while the other bank drains to the FFT

---
 rtl/audio_pingpong_frame_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_audio_pingpong_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pingpong_frame_ctrl.sv
// audio_pingpong_frame_ctrl: ping-pong frame sequencer over one simple-dual-port RAM.
// An input sample stream fills one RAM bank while the other bank drains as framed output.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   s_data/s_valid      input sample stream; s_ready is combinational
//   m_data/m_valid      registered output frame stream with m_last on the final sample
//   m_ready             downstream accept
//   ram_wr_en/addr/data RAM write port, address = {wr_bank, wr_cnt}
//   ram_rd_addr/data    RAM read port, address = {rd_bank, rd_cnt}, data combinational
//   drop_cnt            saturating rejected-sample counter (only with FRAME_DROP_CNT_EN)
//
// Build option: define FRAME_DROP_CNT_EN to add the drop_cnt output and its counter.

module audio_pingpong_frame_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef FRAME_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    // Per-bank sample counter width; the MSB of the RAM address is the bank bit.
    localparam int CNT_W = ADDR_WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Write side state
    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] wr_cnt_q,  wr_cnt_d;
    logic             wr_fire;
    logic             wr_wrap;

    // Read side state
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] rd_cnt_q,  rd_cnt_d;
    logic             rd_load;
    logic             rd_wrap;

    // One full flag per bank, shared by both sides
    logic [1:0]       bank_full_q, bank_full_d;

    // Output register stage
    logic [DATA_WIDTH-1:0] m_data_q,  m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q,  m_last_d;

    //------------------------------------------------------------------
    // Write side
    //------------------------------------------------------------------
    assign s_ready = !bank_full_q[wr_bank_q];

    always_comb begin
        wr_fire   = s_valid && s_ready;
        wr_wrap   = wr_fire && (wr_cnt_q == CNT_LAST);
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (wr_wrap) begin
            // Frame complete: hand the bank to the reader and
            // move on to the other bank.
            wr_cnt_d  = '0;
            wr_bank_d = !wr_bank_q;
        end else if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    assign ram_wr_en   = wr_fire;
    assign ram_wr_addr = {wr_bank_q, wr_cnt_q};
    assign ram_wr_data = s_data;

    //------------------------------------------------------------------
    // Read FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // Read FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Read FSM: outputs and read-side datapath
    //------------------------------------------------------------------
    always_comb begin
        rd_load   = 1'b0;
        rd_wrap   = 1'b0;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    rd_cnt_d = '0;
                end
                // Let the last sample of the previous frame drain.
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            end
            READ: begin
                // The RAM read is combinational, so the sample at
                // rd_cnt is available in the same cycle it is addressed.
                rd_load = !m_valid_q || m_ready;
                if (rd_load) begin
                    m_data_d  = ram_rd_data;
                    m_valid_d = 1'b1;
                    m_last_d  = (rd_cnt_q == CNT_LAST);
                    if (rd_cnt_q == CNT_LAST) begin
                        rd_wrap   = 1'b1;
                        rd_cnt_d  = '0;
                        rd_bank_d = !rd_bank_q;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                rd_load = 1'b0;
            end
        endcase
    end

    assign ram_rd_addr = {rd_bank_q, rd_cnt_q};

    //------------------------------------------------------------------
    // Bank ownership: set by writer, cleared by reader
    //------------------------------------------------------------------
    always_comb begin
        bank_full_d = bank_full_q;
        // Writer and reader never finish on the same bank in one
        // cycle, so both updates can be applied independently.
        if (wr_wrap) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
        if (rd_wrap) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            bank_full_q <= 2'b00;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            bank_full_q <= bank_full_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

    //------------------------------------------------------------------
    // Rejected-sample counter
    //------------------------------------------------------------------
`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (s_valid && !s_ready && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Without the counter, a sample offered while s_ready is low is
    // simply not accepted.
`endif

endmodule

// File: tb/tb_audio_pingpong_frame_ctrl.sv
// tb_audio_pingpong_frame_ctrl: directed bench for the ping-pong frame sequencer.
// Models the 1024x32 RAM with a registered write and combinational read.

module tb_audio_pingpong_frame_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        ram_wr_en;
    logic [9:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic [9:0]  ram_rd_addr;
    logic [31:0] ram_rd_data;
`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mem [0:1023];

    audio_pingpong_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
`ifdef FRAME_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end
    assign ram_rd_data = mem[ram_rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          idx;
        int          guard;
        logic        held;
        logic [31:0] hd;
        logic        hl;
        logic        ev;
        logic [31:0] ed;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef FRAME_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        nxt();
        rst = 1'b0;

        // T1+T2: two frames back-to-back, m_ready=1.
        // Frame A 0..511 written in cycles 0..511, visible 514..1025.
        // Frame B 1000..1511 written 512..1023, visible 1027..1538.
        for (int c = 0; c <= 1540; c++) begin
            if (c < 1024) begin
                s_valid = 1'b1;
                s_data  = (c < 512) ? 32'(c) : 32'(1000 + c - 512);
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 1024) begin
                chk("t1_wr_en", 32'(ram_wr_en), 32'd1);
                chk("t1_wr_addr", 32'(ram_wr_addr), 32'(c));
                chk("t1_s_ready", 32'(s_ready), 32'd1);
            end
            ev = ((c >= 514) && (c <= 1025)) || ((c >= 1027) && (c <= 1538));
            ed = (c <= 1025) ? 32'(c - 514) : 32'(1000 + c - 1027);
            chk("t1_m_valid", 32'(m_valid), 32'(ev));
            if (ev) begin
                chk("t1_m_data", m_data, ed);
                chk("t1_m_last", 32'(m_last), 32'((c == 1025) || (c == 1538)));
            end
            nxt();
        end

        // T3: frame 2000..2511, m_ready toggling once output starts
        for (int k = 0; k < 512; k++) begin
            s_valid = 1'b1;
            s_data  = 32'(2000 + k);
            @(negedge clk);
            chk("t3_wr_addr", 32'(ram_wr_addr), 32'(k));
            nxt();
        end
        s_valid = 1'b0;
        guard   = 0;
        @(negedge clk);
        while (!m_valid && guard < 10) begin
            nxt();
            @(negedge clk);
            guard++;
        end
        chk("t3_latency", 32'(guard), 32'd2);
        idx  = 0;
        held = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        while (idx < 512 && guard < 3000) begin
            chk("t3_m_valid", 32'(m_valid), 32'd1);
            chk("t3_m_data", m_data, 32'(2000 + idx));
            chk("t3_m_last", 32'(m_last), 32'(idx == 511));
            if (held) begin
                chk("t3_hold_data", m_data, hd);
                chk("t3_hold_last", 32'(m_last), 32'(hl));
            end
            held = !m_ready;
            hd   = m_data;
            hl   = m_last;
            if (m_ready) idx++;
            nxt();
            m_ready = !m_ready;
            @(negedge clk);
            guard++;
        end
        chk("t3_count", 32'(idx), 32'd512);
        nxt();
        m_ready = 1'b1;
        nxt();
        @(negedge clk);
        chk("t3_drained", 32'(m_valid), 32'd0);
        nxt();

        // T4: m_ready=0, fill both banks. Writer starts on bank 1.
        m_ready = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            s_valid = 1'b1;
            s_data  = 32'(3000 + k);
            @(negedge clk);
            chk("t4_s_ready", 32'(s_ready), 32'd1);
            chk("t4_wr_addr", 32'(ram_wr_addr), 32'((512 + k) % 1024));
            nxt();
        end
        s_data = 32'd9999;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t4_full_s_ready", 32'(s_ready), 32'd0);
            chk("t4_full_wr_en", 32'(ram_wr_en), 32'd0);
            nxt();
        end
`ifdef FRAME_DROP_CNT_EN
        // T6: three rejects above, then saturation
        @(negedge clk);
        chk("t6_drop_3", 32'(drop_cnt), 32'd3);
        nxt();
        repeat (70000) @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("t6_drop_sat", 32'(drop_cnt), 32'h0000FFFF);
        nxt();
`endif
        s_valid = 1'b0;

        // Release the stall and drain frame 3000..3511
        m_ready = 1'b1;
        for (int j = 0; j < 512; j++) begin
            @(negedge clk);
            chk("t4_m_valid", 32'(m_valid), 32'd1);
            chk("t4_m_data", m_data, 32'(3000 + j));
            chk("t4_m_last", 32'(m_last), 32'(j == 511));
            chk("t4_s_ready", 32'(s_ready), 32'(j == 511));
            nxt();
        end
        @(negedge clk);
        chk("t4_bubble", 32'(m_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("t4_next_valid", 32'(m_valid), 32'd1);
        chk("t4_next_data", m_data, 32'd3512);
        nxt();

        // T5: partial frame into bank 1, then reset mid-operation
        for (int k = 0; k < 100; k++) begin
            s_valid = 1'b1;
            s_data  = 32'(5000 + k);
            @(negedge clk);
            chk("t5_pre_s_ready", 32'(s_ready), 32'd1);
            chk("t5_pre_wr_addr", 32'(ram_wr_addr), 32'(512 + k));
            nxt();
        end
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_m_last", 32'(m_last), 32'd0);
        chk("t5_rst_s_ready", 32'(s_ready), 32'd1);
        nxt();
        rst = 1'b0;
        for (int c = 0; c <= 516; c++) begin
            if (c < 512) begin
                s_valid = 1'b1;
                s_data  = 32'(6000 + c);
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 512) begin
                chk("t5_wr_addr", 32'(ram_wr_addr), 32'(c));
            end
            if (c >= 510) begin
                chk("t5_m_valid", 32'(m_valid), 32'(c >= 514));
                if (c >= 514) begin
                    chk("t5_m_data", m_data, 32'(6000 + c - 514));
                end
            end
            nxt();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
